gba_video_scanout: RTL and testbench
====================================

GBA_VIDEO_SCANOUT -- requirements
Module: gba_video_scanout

Interface
REQ-001 SHALL have parameter CE_DIV, default 4, meaning system clocks per output pixel (power of two, 2..8).
REQ-002 SHALL have parameter WD_BITS, default 16, meaning width of the wait-for-sync watchdog counter, counted in ce_pix ticks.
REQ-003 SHALL have port clk_sys  in  1  system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port pixel_we  in  1  core framebuffer write strobe (snooped only).
REQ-006 SHALL have port pixel_addr  in  16  core framebuffer write address (snooped only).
REQ-007 SHALL have port fb_addr  out  16  framebuffer read address, 0..38399.
REQ-008 SHALL have port fb_q  in  15  framebuffer read data {R[14:10],G[9:5],B[4:0]}, valid 1 clk after fb_addr.
REQ-009 SHALL have port ce_pix  out  1  one-clk pixel enable.
REQ-010 SHALL have port vga_r, vga_g, vga_b  out  8 each  pixel colour.
REQ-011 SHALL have ports hs, vs, hbl, vbl, de  out  1 each  syncs, blanks, de = ~(hbl|vbl).
REQ-012 SHALL have port frame_start  out  1  one-clk pulse when a frame scan begins.

Function
REQ-013 SHALL run a free-running divider div, 0..CE_DIV-1, wrapping to 0.
REQ-014 SHALL have two states: WAIT_SYNC (held idle between frames) and SCAN.
REQ-015 SHALL use counters x and y (8 bits each) in SCAN; each line is 256 pixels; a frame is lines 0..255.
REQ-016 SHALL set sync_pending on the clk where pixel_we=1 and pixel_addr=38399; if that set and a consume fall on the same clk, the set wins.
REQ-017 SHALL, on the edge with div=0, register ce_pix=1 for exactly the following clk; ce_pix SHALL be 0 otherwise, in both states.
REQ-018 SHALL apply the following at that same div=0 edge, in SCAN and from the current x,y:
  - hbl <= (x>=240)
  - vbl <= (y>=160)
  - hs <= 1 at x=244, hs <= 0 at x=252
  - vs <= 1 at x=244,y=163; vs <= 0 at x=244,y=166
  - if x<240 and y<160: colour <= {c[4:0],c[4:2]} per channel from fb_q, and fb_addr <= fb_addr+1
  - otherwise: colour <= 0 and fb_addr is unchanged
REQ-019 SHALL, on the edge with div=1 in SCAN, advance x+1 (wrapping 255->0); on that wrap y advances +1.
REQ-020 SHALL enter WAIT_SYNC when y=255 and x=255 wraps.
REQ-021 SHALL, in WAIT_SYNC, force hbl=vbl=1, de=0, hs=vs=0 and colour=0.
REQ-022 SHALL, in WAIT_SYNC, increment the watchdog wd once per ce_pix tick.
REQ-023 SHALL, on a div=1 edge in WAIT_SYNC when sync_pending=1 or wd is all-ones:
  - clear sync_pending and wd
  - set x=y=0 and fb_addr=0
  - enter SCAN
  - pulse frame_start for 1 clk
REQ-024 SHALL latch a sync arriving during SCAN and consume it at the next WAIT_SYNC; multiple syncs within one frame collapse into one.
REQ-025 SHALL never let fb_addr exceed 38399 (240x160 active pixels per frame).
REQ-026 SHALL keep the read latency at 1 clk: the fb_addr update at a div=0 edge is sampled as fb_q by the next div=0 edge.

Reset
REQ-027 SHALL, while reset=1, asynchronously force:
  - state=WAIT_SYNC
  - div, x, y, wd, fb_addr and sync_pending = 0
  - ce_pix, hs, vs, de, frame_start and colour = 0
  - hbl = vbl = 1
REQ-028 SHALL, after release, begin with div=0 on the first clk.
REQ-029 SHALL, on reset mid-frame, discard the partial frame; scanning resumes only via sync or watchdog.

Verification
REQ-030 Reset release, then a single write pixel_we=1 with pixel_addr=38399 -> frame_start pulses within CE_DIV clks, fb_addr=0, state SCAN.
REQ-031 Framebuffer model with fb_q = fb_addr[14:0] -> first active pixel: vga_r={fb_q[14:10],fb_q[14:12]}; line 0 ends with fb_addr=240; last active pixel fb_addr=38399; 38400 de-high ce_pix ticks per frame.
REQ-032 Full frame -> hs high for x=244..251 on every line; vs high on lines 163..165; hbl=1 for x 240..255; then WAIT_SYNC with de=0.
REQ-033 Two syncs during one frame -> exactly one frame_start after frame end; the next wait holds until a new sync.
REQ-034 No sync with WD_BITS=4 -> frame_start after 16 ce_pix ticks in WAIT_SYNC.
REQ-035 Assert reset at x=100,y=50 -> all outputs at reset values immediately; after release, no SCAN until sync or watchdog.

Source files
------------

// File: rtl/gba_video_scanout.sv
// GBA framebuffer scan-out: reads a 240x160 RGB555 framebuffer inside a
// 256x256 pixel raster and produces 8-bit RGB with syncs and blanks. A frame
// scan starts when the core writes the last framebuffer pixel, or when the
// wait-for-sync watchdog expires.
module gba_video_scanout #(
    parameter int CE_DIV  = 4,
    parameter int WD_BITS = 16
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        pixel_we,
    input  logic [15:0] pixel_addr,
    output logic [15:0] fb_addr,
    input  logic [14:0] fb_q,
    output logic        ce_pix,
    output logic [7:0]  vga_r,
    output logic [7:0]  vga_g,
    output logic [7:0]  vga_b,
    output logic        hs,
    output logic        vs,
    output logic        hbl,
    output logic        vbl,
    output logic        de,
    output logic        frame_start
);

    localparam logic [15:0] LAST_ADDR = 16'd38399;
    localparam logic [2:0]  DIV_MAX   = 3'(CE_DIV - 1);
    localparam logic [WD_BITS-1:0] WD_ONE = {{(WD_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_WAIT_SYNC = 1'b0,
        ST_SCAN      = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [2:0]         r_div;
    logic [7:0]         r_x;
    logic [7:0]         r_y;
    logic [WD_BITS-1:0] r_wd;
    logic               r_sync_pending;
    logic [15:0]        r_fb_addr;
    logic               r_ce_pix;
    logic               r_frame_start;
    logic               r_hs;
    logic               r_vs;
    logic               r_hbl;
    logic               r_vbl;
    logic               r_de;
    logic [7:0]         r_r;
    logic [7:0]         r_g;
    logic [7:0]         r_b;

    logic w_div0;
    logic w_div1;
    logic w_sync_set;
    logic w_consume;
    logic w_frame_end;
    logic w_active;

    // Widen a 5-bit channel to 8 bits by replicating its top bits.
    function automatic logic [7:0] expand5(input logic [4:0] c);
        return {c, c[4:2]};
    endfunction

    assign w_div0      = (r_div == 3'd0);
    assign w_div1      = (r_div == 3'd1);
    assign w_sync_set  = pixel_we && (pixel_addr == LAST_ADDR);
    assign w_consume   = (r_state == ST_WAIT_SYNC) && w_div1 && (r_sync_pending || (&r_wd));
    assign w_frame_end = (r_state == ST_SCAN) && w_div1 && (r_x == 8'd255) && (r_y == 8'd255);
    assign w_active    = (r_x < 8'd240) && (r_y < 8'd160);

    // Free-running pixel clock divider.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_div <= 3'd0;
        end else if (r_div == DIV_MAX) begin
            r_div <= 3'd0;
        end else begin
            r_div <= r_div + 3'd1;
        end
    end

    // Scan state register.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT_SYNC;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state: leave the wait on a sync or watchdog expiry, return at frame end.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_WAIT_SYNC: begin
                if (w_consume) begin
                    w_state_next = ST_SCAN;
                end else begin
                    w_state_next = ST_WAIT_SYNC;
                end
            end
            ST_SCAN: begin
                if (w_frame_end) begin
                    w_state_next = ST_WAIT_SYNC;
                end else begin
                    w_state_next = ST_SCAN;
                end
            end
            default: w_state_next = ST_WAIT_SYNC;
        endcase
    end

    // Latch a write to the last framebuffer pixel; a new sync beats a same-clk consume.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_sync_pending <= 1'b0;
        end else if (w_sync_set) begin
            r_sync_pending <= 1'b1;
        end else if (w_consume) begin
            r_sync_pending <= 1'b0;
        end
    end

    // Watchdog counts pixel ticks spent waiting for a sync.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_wd <= '0;
        end else if (w_consume) begin
            r_wd <= '0;
        end else if ((r_state == ST_WAIT_SYNC) && r_ce_pix) begin
            r_wd <= r_wd + WD_ONE;
        end
    end

    // Raster position, advanced one pixel after each pixel has been emitted.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_x <= 8'd0;
            r_y <= 8'd0;
        end else if (w_consume) begin
            r_x <= 8'd0;
            r_y <= 8'd0;
        end else if ((r_state == ST_SCAN) && w_div1) begin
            r_x <= r_x + 8'd1;
            if (r_x == 8'd255) begin
                r_y <= r_y + 8'd1;
            end
        end
    end

    // Read address: steps through active pixels, parked at 0 between frames so
    // the first pixel is already on fb_q when the next scan starts.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_fb_addr <= 16'd0;
        end else if (w_consume || w_frame_end) begin
            r_fb_addr <= 16'd0;
        end else if ((r_state == ST_SCAN) && w_div0 && w_active && (r_fb_addr != LAST_ADDR)) begin
            r_fb_addr <= r_fb_addr + 16'd1;
        end
    end

    // Pixel-rate outputs: strobe, frame pulse, syncs, blanks and colour.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ce_pix      <= 1'b0;
            r_frame_start <= 1'b0;
            r_hs          <= 1'b0;
            r_vs          <= 1'b0;
            r_hbl         <= 1'b1;
            r_vbl         <= 1'b1;
            r_de          <= 1'b0;
            r_r           <= 8'd0;
            r_g           <= 8'd0;
            r_b           <= 8'd0;
        end else begin
            r_ce_pix      <= w_div0;
            r_frame_start <= w_consume;
            if (r_state == ST_WAIT_SYNC) begin
                r_hs  <= 1'b0;
                r_vs  <= 1'b0;
                r_hbl <= 1'b1;
                r_vbl <= 1'b1;
                r_de  <= 1'b0;
                r_r   <= 8'd0;
                r_g   <= 8'd0;
                r_b   <= 8'd0;
            end else if (w_div0) begin
                r_hbl <= (r_x >= 8'd240);
                r_vbl <= (r_y >= 8'd160);
                r_de  <= w_active;
                if (r_x == 8'd244) begin
                    r_hs <= 1'b1;
                end else if (r_x == 8'd252) begin
                    r_hs <= 1'b0;
                end
                if ((r_x == 8'd244) && (r_y == 8'd163)) begin
                    r_vs <= 1'b1;
                end else if ((r_x == 8'd244) && (r_y == 8'd166)) begin
                    r_vs <= 1'b0;
                end
                if (w_active) begin
                    r_r <= expand5(fb_q[14:10]);
                    r_g <= expand5(fb_q[9:5]);
                    r_b <= expand5(fb_q[4:0]);
                end else begin
                    r_r <= 8'd0;
                    r_g <= 8'd0;
                    r_b <= 8'd0;
                end
            end
        end
    end

    assign fb_addr     = r_fb_addr;
    assign ce_pix      = r_ce_pix;
    assign frame_start = r_frame_start;
    assign hs          = r_hs;
    assign vs          = r_vs;
    assign hbl         = r_hbl;
    assign vbl         = r_vbl;
    assign de          = r_de;
    assign vga_r       = r_r;
    assign vga_g       = r_g;
    assign vga_b       = r_b;

endmodule

// File: tb/tb_gba_video_scanout.sv
// Directed bench for gba_video_scanout: reset values, sync-triggered and
// watchdog-triggered frame starts, a full frame checked pixel by pixel,
// sync collapsing, and reset in the middle of a frame.
module tb_gba_video_scanout;

    localparam int CE = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pixel_we = 1'b0;
    logic [15:0] pixel_addr = 16'd0;

    logic [15:0] fb_addr;
    logic [14:0] fb_q = 15'd0;
    logic        ce_pix;
    logic [7:0]  vga_r, vga_g, vga_b;
    logic        hs, vs, hbl, vbl, de, frame_start;

    logic [15:0] wfb_addr;
    logic [14:0] wfb_q = 15'd0;
    logic        wce;
    logic [7:0]  wr, wg, wb;
    logic        whs, wvs, whbl, wvbl, wde, wfs;

    int n_total = 0;
    int n_bad   = 0;

    int fs_count    = 0;
    int frames_done = 0;
    int de_ticks    = 0;
    int mon_t       = 0;
    int kc          = 0;
    bit mon_active  = 1'b0;

    gba_video_scanout #(.CE_DIV(CE), .WD_BITS(16)) dut (
        .clk_sys(clk), .reset(reset), .pixel_we(pixel_we), .pixel_addr(pixel_addr),
        .fb_addr(fb_addr), .fb_q(fb_q), .ce_pix(ce_pix),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .hs(hs), .vs(vs), .hbl(hbl), .vbl(vbl), .de(de), .frame_start(frame_start)
    );

    gba_video_scanout #(.CE_DIV(CE), .WD_BITS(4)) dut_wd (
        .clk_sys(clk), .reset(reset), .pixel_we(1'b0), .pixel_addr(16'd0),
        .fb_addr(wfb_addr), .fb_q(wfb_q), .ce_pix(wce),
        .vga_r(wr), .vga_g(wg), .vga_b(wb),
        .hs(whs), .vs(wvs), .hbl(whbl), .vbl(wvbl), .de(wde), .frame_start(wfs)
    );

    always #5 clk = ~clk;

    // Framebuffer model: each word holds its own address, one clock read latency.
    always @(posedge clk) begin
        fb_q  <= fb_addr[14:0];
        wfb_q <= wfb_addr[14:0];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic write_px(input logic [15:0] a);
        @(posedge clk);
        #2 pixel_we = 1'b1;
        pixel_addr = a;
        @(posedge clk);
        #2 pixel_we = 1'b0;
    endtask

    task automatic wait_fs(input int bound, output int cyc);
        cyc = -1;
        for (int i = 1; i <= bound && cyc < 0; i++) begin
            @(negedge clk);
            #1;
            if (frame_start) cyc = i;
        end
    endtask

    // Raster monitor: tracks the expected position from frame_start and checks every pixel tick.
    initial begin
        logic [7:0]  x, y;
        logic [15:0] p, pa;
        logic        act, ehs, evs;
        forever begin
            @(negedge clk);
            if (reset) begin
                mon_active = 1'b0;
                kc = 0;
            end else begin
                check_eq("ce_pattern", 32'(ce_pix), 32'(kc % CE == 1));
                check_eq("wd_ce_pattern", 32'(wce), 32'(kc % CE == 1));
                kc++;
                if (frame_start) begin
                    fs_count++;
                    mon_active = 1'b1;
                    mon_t = 0;
                    de_ticks = 0;
                end else if (mon_active) begin
                    if (ce_pix) begin
                        x = mon_t[7:0];
                        y = mon_t[15:8];
                        act = (x < 8'd240) && (y < 8'd160);
                        ehs = (x >= 8'd244) && (x <= 8'd251);
                        evs = ((y == 8'd163) && (x >= 8'd244)) || (y == 8'd164) || (y == 8'd165)
                              || ((y == 8'd166) && (x < 8'd244));
                        check_eq("sync_blank", 32'({hs, vs, hbl, vbl, de}),
                                 32'({ehs, evs, x >= 8'd240, y >= 8'd160, act}));
                        if (act) begin
                            p  = 16'(y) * 16'd240 + 16'(x);
                            pa = (p == 16'd38399) ? 16'd38399 : p + 16'd1;
                            check_eq("rgb", 32'({vga_r, vga_g, vga_b}),
                                     32'({p[14:10], p[14:12], p[9:5], p[9:7], p[4:0], p[4:2]}));
                            check_eq("addr_step", 32'(fb_addr), 32'(pa));
                            de_ticks++;
                        end else begin
                            check_eq("rgb_blank", 32'({vga_r, vga_g, vga_b}), 32'd0);
                        end
                        if (x == 8'd240 && y == 8'd0) check_eq("line0_end_addr", 32'(fb_addr), 32'd240);
                        if (x == 8'd239 && y == 8'd159) check_eq("last_addr", 32'(fb_addr), 32'd38399);
                        if (mon_t == 65535) begin
                            check_eq("de_ticks", 32'(de_ticks), 32'd38400);
                            mon_active = 1'b0;
                            frames_done++;
                        end
                        mon_t++;
                    end
                end else begin
                    check_eq("idle_out", 32'({hs, vs, hbl, vbl, de, vga_r, vga_g, vga_b}),
                             32'({5'b00110, 24'd0}));
                end
            end
        end
    end

    // Main sequence.
    initial begin
        int  cyc;
        int  ticks;
        bit  seen;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_ctl", 32'({ce_pix, hs, vs, de, frame_start, hbl, vbl}), 32'(7'b0000011));
        check_eq("rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check_eq("rst_addr", 32'(fb_addr), 32'd0);
        check_eq("wd_rst", 32'({wce, whs, wvs, wde, wfs, whbl, wvbl, wr, wg, wb}), 32'({7'b0000011, 24'd0}));
        check_eq("wd_rst_addr", 32'(wfb_addr), 32'd0);

        // Release; the 4-bit watchdog instance must start after 16 pixel ticks.
        @(posedge clk);
        #2 reset = 1'b0;
        ticks = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            #1;
            if (wfs) seen = 1'b1;
            else if (wce) ticks++;
        end
        check_eq("wd_fired", 32'(seen), 32'd1);
        check_eq("wd_ticks", 32'(ticks), 32'd16);
        check_eq("no_start_idle", 32'(fs_count), 32'd0);

        // Non-matching write must not start a frame.
        write_px(16'd38398);
        wait_fs(20, cyc);
        check_eq("no_start_bad_addr", 32'(cyc), 32'hFFFF_FFFF);

        // Sync write starts the scan promptly with the address at 0.
        write_px(16'd38399);
        wait_fs(CE + 1, cyc);
        check_eq("sync_latency_ok", 32'(cyc >= 1 && cyc <= CE + 1), 32'd1);
        check_eq("start_addr", 32'(fb_addr), 32'd0);

        // Two syncs during frame A collapse into one start after the frame.
        for (int i = 0; i < 5000 && mon_t < 1000; i++) begin
            @(negedge clk);
            #1;
        end
        write_px(16'd38399);
        for (int i = 0; i < 70000 && mon_t < 30000; i++) begin
            @(negedge clk);
            #1;
        end
        write_px(16'd38399);
        for (int i = 0; i < 140000 && frames_done < 1; i++) begin
            @(negedge clk);
            #1;
        end
        check_eq("frameA_done", 32'(frames_done), 32'd1);
        check_eq("wait_de", 32'({de, hbl, vbl}), 32'(3'b011));
        wait_fs(10, cyc);
        check_eq("latched_start", 32'(cyc > 0), 32'd1);
        check_eq("one_start", 32'(fs_count), 32'd2);

        // Reset in frame B at x=100, y=50.
        for (int i = 0; i < 40000 && !(mon_active && mon_t >= 12900); i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #2;
        check_eq("pre_rst_de", 32'(de), 32'd1);
        check_eq("pre_rst_addr_nz", 32'(fb_addr != 16'd0), 32'd1);
        reset = 1'b1;
        #1;
        check_eq("mid_rst_ctl", 32'({ce_pix, hs, vs, de, frame_start, hbl, vbl}), 32'(7'b0000011));
        check_eq("mid_rst_rgb", 32'({vga_r, vga_g, vga_b}), 32'd0);
        check_eq("mid_rst_addr", 32'(fb_addr), 32'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // After reset, no scan until a new sync, even with non-sync writes.
        pixel_addr = 16'd38399;
        repeat (50) @(posedge clk);
        write_px(16'd38398);
        wait_fs(400, cyc);
        check_eq("hold_after_rst", 32'(cyc), 32'hFFFF_FFFF);
        check_eq("hold_count", 32'(fs_count), 32'd2);

        write_px(16'd38399);
        wait_fs(CE + 1, cyc);
        check_eq("resync_start", 32'(cyc > 0), 32'd1);
        check_eq("resync_addr", 32'(fb_addr), 32'd0);
        repeat (20) @(posedge clk);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
